serial_addsub_4bit: RTL

- Bit-serial adder/subtractor core for the 4-bit binary calculator.
- Drives a single full_adder_1bit instance one bit per clock, LSB first, with the carry held in a flop between cycles.
- Sits between the operand/keypad input stage and the result display stage.
- Upstream gives it a start pulse plus operands; it returns a registered result with a one-cycle done pulse.

---
 rtl/calc_pkg.sv | 15 +
 rtl/full_adder_1bit.sv | 16 +
 rtl/serial_addsub_4bit.sv | 105 ++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the 4-bit calculator datapath blocks.
package calc_pkg;

    // Sequencer states of the bit-serial arithmetic core.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Operation select as driven by the keypad stage.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder; the only arithmetic element of the serial core.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational sum and carry.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_addsub_4bit.sv
// Bit-serial add/subtract core: one full adder walked LSB-first over WIDTH
// cycles, carry kept in a flop. Results are registered and only change on
// the transition into DONE, which is flagged by a one-cycle done pulse.
module serial_addsub_4bit
    import calc_pkg::*;
#(
    parameter int WIDTH = 4   // operand/result width, must be >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    // Bit index of the MSB and the one just below it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_sr;     // sum bits fill in from the MSB side
    logic             carry;      // carry between bit slices
    logic             carry_msb;  // carry into the MSB, for signed overflow
    logic [CNT_W-1:0] cnt;

    logic fa_sum;
    logic fa_cout;

    full_adder_1bit u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Sequencer plus datapath registers; outputs are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Result    <= '0;
            Cout      <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtract as A + ~B + 1: invert B, seed the carry.
                        op_a   <= A;
                        op_b   <= (op_sub == OP_SUB) ? ~B : B;
                        carry  <= op_sub;
                        cnt    <= '0;
                        sum_sr <= '0;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_PEN)
                        carry_msb <= fa_cout;
                    if (cnt == CNT_LAST) begin
                        Result   <= {fa_sum, sum_sr[WIDTH-1:1]};
                        Cout     <= fa_cout;
                        Overflow <= carry_msb ^ fa_cout;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here.
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
